fwrisc_mem_arbiter: RTL and testbench

// - Shares one memory bus between the fetch port (i*) and the load/store port (d*) of the core.
// - Grants one requester at a time and forwards its request to the memory (m*) port.
// - Routes mready and mrdata back to the granted requester.
// - Sits between fwrisc_fetch / LSU and the system memory or bus bridge.

---
 rtl/fwrisc_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_fwrisc_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_mem_arbiter.sv
// fwrisc_mem_arbiter
// Shares one memory bus between the fetch port (i*) and the load/store
// port (d*). One requester is granted at a time; its request is forwarded
// to the memory (m*) port, and mready/mrdata are routed back to it.
// Every transaction is followed by at least one IDLE cycle.
//
// Build option:
//   FWRISC_MEM_ARB_RR_EN  defined   -> strict round-robin when both request
//                         undefined -> data priority, with fetch forced in
//                                      after MAX_D_BURST back-to-back data
//                                      grants while a fetch is waiting
//
// Ports:
//   clock, reset       clock and synchronous active-low reset
//   iaddr/ivalid       fetch request in; iready/idata fetch response out
//   daddr/dwdata/dwstb/dwrite/dvalid  data request in; dready/drdata out
//   maddr/mwdata/mwstb/mwrite/mvalid  memory request out; mready/mrdata in
//   busy               high while a grant is outstanding
module fwrisc_mem_arbiter #(
    parameter int unsigned MAX_D_BURST = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] iaddr,
    input  logic        ivalid,
    output logic        iready,
    output logic [31:0] idata,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwstb,
    input  logic        dwrite,
    input  logic        dvalid,
    output logic        dready,
    output logic [31:0] drdata,
    output logic [31:0] maddr,
    output logic [31:0] mwdata,
    output logic [3:0]  mwstb,
    output logic        mwrite,
    output logic        mvalid,
    input  logic        mready,
    input  logic [31:0] mrdata,
    output logic        busy
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t r_state;
    logic   w_gnt_i;
    logic   w_gnt_d;
    logic   w_pick_d;

`ifdef FWRISC_MEM_ARB_RR_EN
    // 1 = most recent grant went to the data port
    logic r_last_d;

    // On contention, serve the port that was not served last
    assign w_pick_d = dvalid && (!ivalid || !r_last_d);
`else
    logic [CNT_W-1:0] r_burst_cnt;

    // Data wins contention until it has taken MAX_D_BURST grants in a row
    // against a waiting fetch
    assign w_pick_d = dvalid && (!ivalid || (r_burst_cnt != CNT_W'(MAX_D_BURST)));
`endif

    // Arbitration happens only in IDLE; an issued grant is held until mready
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
`ifdef FWRISC_MEM_ARB_RR_EN
            r_last_d <= 1'b0;
`else
            r_burst_cnt <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (ivalid || dvalid) begin
                        r_state <= w_pick_d ? GNT_D : GNT_I;
`ifdef FWRISC_MEM_ARB_RR_EN
                        r_last_d <= w_pick_d;
`else
                        // Count only data grants that make a fetch wait; saturate
                        if (!w_pick_d || !ivalid) begin
                            r_burst_cnt <= '0;
                        end else if (r_burst_cnt != CNT_W'(MAX_D_BURST)) begin
                            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                        end
`endif
                    end
                end
                GNT_I, GNT_D: begin
                    if (mready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_gnt_i = (r_state == GNT_I);
    assign w_gnt_d = (r_state == GNT_D);

    assign mvalid = w_gnt_i || w_gnt_d;
    assign busy   = w_gnt_i || w_gnt_d;

    // Request mux; fetches are always reads with no write payload
    assign maddr  = w_gnt_d ? daddr  : iaddr;
    assign mwdata = w_gnt_d ? dwdata : 32'h0;
    assign mwstb  = w_gnt_d ? dwstb  : 4'h0;
    assign mwrite = w_gnt_d && dwrite;

    // Completion goes to the granted port only; read data is shared
    assign iready = w_gnt_i && mready;
    assign dready = w_gnt_d && mready;
    assign idata  = mrdata;
    assign drdata = mrdata;

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// Testbench for fwrisc_mem_arbiter (default data-priority build).
module tb_fwrisc_mem_arbiter;

    localparam int unsigned MAXB = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] iaddr;
    logic        ivalid;
    logic        iready;
    logic [31:0] idata;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwstb;
    logic        dwrite;
    logic        dvalid;
    logic        dready;
    logic [31:0] drdata;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mwstb;
    logic        mwrite;
    logic        mvalid;
    logic        mready;
    logic [31:0] mrdata;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    fwrisc_mem_arbiter #(.MAX_D_BURST(MAXB)) dut (
        .clock (clock),
        .reset (reset),
        .iaddr (iaddr),
        .ivalid(ivalid),
        .iready(iready),
        .idata (idata),
        .daddr (daddr),
        .dwdata(dwdata),
        .dwstb (dwstb),
        .dwrite(dwrite),
        .dvalid(dvalid),
        .dready(dready),
        .drdata(drdata),
        .maddr (maddr),
        .mwdata(mwdata),
        .mwstb (mwstb),
        .mwrite(mwrite),
        .mvalid(mvalid),
        .mready(mready),
        .mrdata(mrdata),
        .busy  (busy)
    );

    // sel: 0 = no grant, 1 = fetch granted, 2 = data granted.
    // Expected bus fields come from the bench's own request drive values.
    task automatic check(input string name, input logic e_mv, input int sel,
                         input logic e_ir, input logic e_dr);
        logic ok;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [3:0]  e_stb;
        logic        e_wr;
        e_addr = (sel == 2) ? daddr : iaddr;
        e_wd   = (sel == 2) ? dwdata : 32'h0;
        e_stb  = (sel == 2) ? dwstb : 4'h0;
        e_wr   = (sel == 2) ? dwrite : 1'b0;
        ok = (mvalid === e_mv) && (busy === e_mv) && (iready === e_ir) &&
             (dready === e_dr) && (idata === mrdata) && (drdata === mrdata) &&
             (mwstb === e_stb) && (mwrite === e_wr);
        if (sel != 0)
            ok = ok && (maddr === e_addr) && (mwdata === e_wd);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s @%0t: got mvalid=%b busy=%b iready=%b dready=%b maddr=%h mwdata=%h mwstb=%b mwrite=%b; want mvalid=%b grant=%0d iready=%b dready=%b maddr=%h mwdata=%h mwstb=%b mwrite=%b",
                     name, $time, mvalid, busy, iready, dready, maddr, mwdata, mwstb, mwrite,
                     e_mv, sel, e_ir, e_dr, e_addr, e_wd, e_stb, e_wr);
        end
    endtask

    typedef struct {
        logic rst_n;
        logic iv;
        logic dv;
        logic dw;
        logic mr;
        logic e_mv;
        int   e_sel;
        logic e_ir;
        logic e_dr;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   order[$];
        int   exp_order[6];
        logic seen;
        int   m_cur;
        int   m_streak;
        logic e_ir;
        logic e_dr;

        //            rst iv dv dw mr   mv sel ir dr
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1,  1'b0, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0,  1'b0, 0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1,  1'b1, 1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,  1'b0, 0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,  1'b1, 2, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,  1'b1, 2, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1,  1'b1, 1, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1,  1'b0, 0, 1'b0, 1'b0};

        reset  = 1'b0;
        ivalid = 1'b0;
        dvalid = 1'b0;
        dwrite = 1'b0;
        mready = 1'b0;
        iaddr  = 32'h0000_0100;
        daddr  = 32'h0000_0200;
        dwdata = 32'hA5A5_0000;
        dwstb  = 4'b0011;
        mrdata = 32'hDEAD_BEEF;
        @(posedge clock);
        #1;

        // Reset hold, lone fetch latency, contention, idle mready
        for (int i = 0; i < 14; i++) begin
            reset  = tbl[i].rst_n;
            ivalid = tbl[i].iv;
            dvalid = tbl[i].dv;
            dwrite = tbl[i].dw;
            mready = tbl[i].mr;
            @(negedge clock);
            check($sformatf("tbl%0d", i), tbl[i].e_mv, tbl[i].e_sel, tbl[i].e_ir, tbl[i].e_dr);
            @(posedge clock);
            #1;
        end

        // Starvation limit: both ports request continuously
        exp_order = '{2, 2, 2, 2, 1, 2};
        reset  = 1'b1;
        ivalid = 1'b1;
        dvalid = 1'b1;
        dwrite = 1'b0;
        mready = 1'b0;
        seen   = 1'b0;
        for (int c = 0; c < 60 && order.size() < 6; c++) begin
            @(negedge clock);
            seen = mvalid && !mready;
            if (seen)
                order.push_back((maddr == daddr) ? 2 : 1);
            @(posedge clock);
            #1;
            mready = seen;
        end
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if (k >= order.size() || order[k] != exp_order[k]) begin
                n_bad++;
                $display("FAIL grant_order[%0d]: got %0d, want %0d (1=I 2=D, 0=none)",
                         k, (k < order.size()) ? order[k] : 0, exp_order[k]);
            end
        end
        @(posedge clock);
        #1;
        mready = 1'b0;
        ivalid = 1'b0;
        dvalid = 1'b0;
        reset  = 1'b0;
        @(posedge clock);
        #1;

        // Mid-operation reset abandons the grant; a late mready is ignored
        reset  = 1'b1;
        dvalid = 1'b1;
        dwrite = 1'b1;
        daddr  = 32'h0000_0300;
        @(negedge clock);
        check("midop_idle", 1'b0, 0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("midop_gnt", 1'b1, 2, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset  = 1'b1;
        dvalid = 1'b0;
        mready = 1'b1;
        @(negedge clock);
        check("midop_late_mready", 1'b0, 0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        mready = 1'b0;

        // Random traffic against a transaction-level reference model
        m_cur    = 0;
        m_streak = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!ivalid && ($urandom % 3 == 0)) begin
                ivalid = 1'b1;
                iaddr  = $urandom & 32'hFFFF_FFFC;
            end
            if (!dvalid && ($urandom % 3 == 0)) begin
                dvalid = 1'b1;
                daddr  = $urandom;
                dwdata = $urandom;
                dwstb  = 4'($urandom);
                dwrite = 1'($urandom);
            end
            mrdata = $urandom;
            mready = (m_cur != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            @(negedge clock);
            e_ir = (m_cur == 1) && mready;
            e_dr = (m_cur == 2) && mready;
            check("rand", m_cur != 0, m_cur, e_ir, e_dr);
            if (m_cur == 0) begin
                if (dvalid && (!ivalid || m_streak < int'(MAXB))) begin
                    m_cur    = 2;
                    m_streak = ivalid ? m_streak + 1 : 0;
                end else if (ivalid) begin
                    m_cur    = 1;
                    m_streak = 0;
                end
            end else if (mready) begin
                m_cur = 0;
            end
            @(posedge clock);
            #1;
            if (e_ir) ivalid = 1'b0;
            if (e_dr) dvalid = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
